// File: rtl/ov7670_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_cfg_pkg
// Shared definitions for the OV7670 configuration sequencer:
//   cfg_state_t  - sequencer state encoding
//   CFG_END      - ROM word that terminates a configuration run
//   CFG_DELAY    - ROM word that requests a programmable wait
//   CFG_ADDR_W   - configuration ROM address width
//   cnt_width()  - counter width able to hold 0 .. n-1 (never below 1 bit)
// ---------------------------------------------------------------------------
package ov7670_cfg_pkg;

  localparam int unsigned CFG_ADDR_W = 8;
  localparam logic [15:0] CFG_END    = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY  = 16'hFFF0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_WAIT,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ov7670_cfg_delay_timer.sv
// ---------------------------------------------------------------------------
// ov7670_cfg_delay_timer
// Loadable down-counter used for the configuration delay entries.
// Parameters:
//   WIDTH    counter width
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   load     in   load `value` into the counter
//   value    in   WIDTH  reload value
//   expired  out  counter is at zero
// The counter stops at zero; loading takes priority over counting.
// ---------------------------------------------------------------------------
module ov7670_cfg_delay_timer
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// ov7670_cfg_sequencer
// Walks the OV7670 configuration ROM from address 0, issuing one SCCB
// register write per entry, inserting a timed wait for delay entries and
// stopping at the end marker (or after the entry at the last address).
//
// Parameters:
//   CLK_FREQ_HZ  clk frequency in Hz
//   DELAY_MS     wait applied for each delay entry, in ms
//   MAX_RETRY    retries per entry on NACK (retry build only)
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle pulse starting a run (IDLE/DONE/ERROR only)
//   rom_addr     out 8   ROM address
//   rom_data     in  16  ROM word {reg, value}, one cycle after rom_addr
//   sccb_valid   out     write request, held until sccb_ready
//   sccb_ready   in      SCCB master accepts the request
//   sccb_reg     out 8   register address
//   sccb_data    out 8   register value
//   sccb_done    in      transaction finished pulse
//   sccb_nack    in      slave NACK, qualified by sccb_done
//   busy/done/error out  run status; done/error held until next start
// Build option:
//   OV7670_CFG_RETRY_EN  when defined, a NACKed entry is resent up to
//                        MAX_RETRY times before the run is aborted.
// ---------------------------------------------------------------------------
module ov7670_cfg_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned DELAY_MS    = 10,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [CFG_ADDR_W-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  output logic                  sccb_valid,
  input  logic                  sccb_ready,
  output logic [7:0]            sccb_reg,
  output logic [7:0]            sccb_data,
  input  logic                  sccb_done,
  input  logic                  sccb_nack,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned     DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
  localparam int unsigned     DLY_W        = cnt_width(DELAY_CYCLES);
  // Counting N-1 down to 0 inclusive gives exactly N cycles in DELAY.
  localparam logic [DLY_W-1:0] DLY_LOAD    = DLY_W'(DELAY_CYCLES - 1);

  cfg_state_t            r_state;
  logic [CFG_ADDR_W-1:0] r_rom_addr;
  logic                  r_valid;
  logic [7:0]            r_reg;
  logic [7:0]            r_data;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic w_dly_load;
  logic w_dly_expired;
  logic w_last_entry;

`ifdef OV7670_CFG_RETRY_EN
  localparam int unsigned        RETRY_W   = cnt_width(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] r_retry;
`endif

  assign w_dly_load   = (r_state == ST_DECODE) && (rom_data == CFG_DELAY);
  // The address never wraps: finishing the last entry ends the run.
  assign w_last_entry = (r_rom_addr == '1);

  ov7670_cfg_delay_timer #(
    .WIDTH(DLY_W)
  ) u_delay_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_dly_load),
    .value  (DLY_LOAD),
    .expired(w_dly_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rom_addr <= '0;
      r_valid    <= 1'b0;
      r_reg      <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef OV7670_CFG_RETRY_EN
      r_retry    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_state    <= ST_FETCH;
            r_rom_addr <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef OV7670_CFG_RETRY_EN
            r_retry    <= '0;
`endif
          end
        end

        ST_FETCH: begin
          r_state <= ST_DECODE;
        end

        ST_DECODE: begin
          if (rom_data == CFG_END) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (rom_data == CFG_DELAY) begin
            r_state <= ST_DELAY;
          end else begin
            r_reg   <= rom_data[15:8];
            r_data  <= rom_data[7:0];
            r_valid <= 1'b1;
            r_state <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (sccb_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (sccb_done) begin
            if (!sccb_nack) begin
`ifdef OV7670_CFG_RETRY_EN
              r_retry <= '0;
`endif
              if (w_last_entry) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_rom_addr <= r_rom_addr + 1'b1;
                r_state    <= ST_FETCH;
              end
            end else begin
`ifdef OV7670_CFG_RETRY_EN
              // Resend from the latched reg/data; the ROM is not re-read.
              if (r_retry < RETRY_MAX) begin
                r_retry <= r_retry + 1'b1;
                r_valid <= 1'b1;
                r_state <= ST_SEND;
              end else begin
                r_state <= ST_ERROR;
                r_busy  <= 1'b0;
                r_error <= 1'b1;
              end
`else
              r_state <= ST_ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
`endif
            end
          end
        end

        ST_DELAY: begin
          if (w_dly_expired) begin
            if (w_last_entry) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_rom_addr <= r_rom_addr + 1'b1;
              r_state    <= ST_FETCH;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign sccb_valid = r_valid;
  assign sccb_reg   = r_reg;
  assign sccb_data  = r_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ov7670_cfg_sequencer
// Directed bench for ov7670_cfg_sequencer. A transaction-level model walks
// the ROM image and NACK script to predict every SCCB request (register,
// value, ROM address, latency from the triggering start/done) and the end
// of each run; a single compare process checks the DUT against it on every
// cycle. Retry scenarios follow OV7670_CFG_RETRY_EN.
// ---------------------------------------------------------------------------
module tb_ov7670_cfg_sequencer;

  localparam int unsigned CLK_HZ  = 1_000_000;
  localparam int unsigned DLY_MS  = 1;
  localparam int unsigned N_DLY   = CLK_HZ / 1000 * DLY_MS;
  localparam int unsigned MAXR    = 3;
  localparam int unsigned ACK_LAT = 10;
`ifdef OV7670_CFG_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  rg;
    logic [7:0]  dt;
    logic [7:0]  addr;
    int unsigned lat;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        sccb_valid;
  logic        sccb_ready = 1'b1;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_data;
  logic        sccb_done = 1'b0;
  logic        sccb_nack = 1'b0;
  logic        busy;
  logic        done;
  logic        error;

  logic [15:0] rom [0:255];
  bit          nack_script[$];
  bit          nack_model[$];
  int unsigned acc_count = 0;

  req_t        exp_q[$];
  bit          end_err;
  logic [7:0]  end_addr;
  int unsigned end_lat;

  int n_vec = 0;
  int n_err = 0;

  bit run_active = 1'b0;

  ov7670_cfg_sequencer #(
    .CLK_FREQ_HZ(CLK_HZ),
    .DELAY_MS   (DLY_MS),
    .MAX_RETRY  (MAXR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .sccb_valid(sccb_valid),
    .sccb_ready(sccb_ready),
    .sccb_reg  (sccb_reg),
    .sccb_data (sccb_data),
    .sccb_done (sccb_done),
    .sccb_nack (sccb_nack),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Registered configuration ROM.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SCCB master model: accepts when valid&&ready, finishes ACK_LAT cycles later.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst && sccb_valid && sccb_ready) begin
        acc_count++;
        repeat (ACK_LAT - 1) @(posedge clk);
        #1;
        sccb_done = 1'b1;
        sccb_nack = (nack_script.size() > 0) ? nack_script.pop_front() : 1'b0;
        @(posedge clk);
        #1;
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
      end
    end
  end

  // Transaction-level model. Latencies count cycles after the trigger edge
  // (start or sccb_done): a write entry needs FETCH, DECODE, SEND (3); each
  // delay entry in front of it adds FETCH, DECODE and N wait cycles.
  task automatic build_model();
    int unsigned addr = 0;
    int unsigned acc = 0;
    int unsigned nk = 0;
    int unsigned tries;
    int unsigned lat;
    logic [15:0] w;
    bit          nk_bit;
    req_t        r;
    exp_q.delete();
    forever begin
      w = rom[addr];
      if (w == 16'hFFFF) begin
        end_err = 1'b0; end_addr = 8'(addr); end_lat = acc + 3;
        return;
      end
      if (w == 16'hFFF0) begin
        acc += N_DLY + 2;
      end else begin
        lat = acc + 3;
        tries = 0;
        forever begin
          r.rg = w[15:8]; r.dt = w[7:0]; r.addr = 8'(addr); r.lat = lat;
          exp_q.push_back(r);
          nk_bit = (nk < nack_model.size()) ? nack_model[nk] : 1'b0;
          nk++;
          if (!nk_bit) break;
          if (RETRY_EN && tries < MAXR) begin
            tries++;
            lat = 1;
          end else begin
            end_err = 1'b1; end_addr = 8'(addr); end_lat = 1;
            return;
          end
        end
        acc = 0;
      end
      if (addr == 255) begin
        end_err = 1'b0; end_addr = 8'd255; end_lat = acc + 1;
        return;
      end
      addr++;
    end
  endtask

  // Compare process: inputs as sampled at the edge, outputs checked at negedge.
  initial begin
    req_t        cq[$];
    bit          in_send = 1'b0;
    bit          waiting = 1'b0;
    bit          exp_done = 1'b0;
    bit          exp_error = 1'b0;
    bit          c_err = 1'b0;
    logic [7:0]  c_addr = '0;
    int unsigned c_lat = 0;
    int unsigned since = 0;
    bit          s_start, s_done, s_acc;
    forever begin
      @(posedge clk);
      s_start = start;
      s_done  = sccb_done;
      s_acc   = sccb_valid && sccb_ready;
      @(negedge clk);
      if (rst) begin
        run_active = 1'b0; in_send = 1'b0; waiting = 1'b0;
        exp_done = 1'b0; exp_error = 1'b0; cq.delete();
        chk("rst_busy", busy, 0);
        chk("rst_valid", sccb_valid, 0);
        chk("rst_flags", {done, error}, 0);
      end else begin
        since++;
        if (s_start && !run_active) begin
          run_active = 1'b1; since = 1; cq = exp_q;
          c_err = end_err; c_addr = end_addr; c_lat = end_lat;
          in_send = 1'b0; waiting = 1'b0; exp_done = 1'b0; exp_error = 1'b0;
        end
        if (run_active && s_acc) begin
          chk("accept_while_sending", in_send, 1);
          in_send = 1'b0;
          waiting = 1'b1;
          if (cq.size() > 0) void'(cq.pop_front());
        end
        if (run_active && waiting && s_done) begin
          waiting = 1'b0;
          since = 1;
        end
        if (run_active && !in_send && !waiting && cq.size() > 0 && since == cq[0].lat)
          in_send = 1'b1;
        if (in_send) begin
          chk("valid_high", sccb_valid, 1);
          chk("sccb_reg", sccb_reg, cq[0].rg);
          chk("sccb_data", sccb_data, cq[0].dt);
          chk("req_rom_addr", rom_addr, cq[0].addr);
        end else begin
          chk("valid_low", sccb_valid, 0);
        end
        if (run_active && !in_send && !waiting && cq.size() == 0 && since == c_lat) begin
          run_active = 1'b0;
          exp_done = !c_err;
          exp_error = c_err;
          chk("end_rom_addr", rom_addr, c_addr);
        end
        chk("busy", busy, run_active);
        chk("done", done, exp_done);
        chk("error", error, exp_error);
      end
    end
  end

  task automatic load_rom(input logic [15:0] w[$]);
    for (int i = 0; i < 256; i++) rom[i] = (i < w.size()) ? w[i] : 16'hFFFF;
  endtask

  task automatic set_nacks(input bit n[$]);
    nack_script = n;
    nack_model = n;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_run(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (run_active && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk({name, "_timeout"}, run_active, 0);
    if (run_active) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic wait_acc(input string name, input int unsigned cnt);
    int unsigned n = 0;
    while (acc_count < cnt && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_acc_wait"}, acc_count >= cnt, 1);
  endtask

  task automatic post_checks(input string name);
    chk({name, "_accepts"}, acc_count, exp_q.size());
    chk({name, "_done"}, done, !end_err);
    chk({name, "_error"}, error, end_err);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_addr"}, rom_addr, end_addr);
  endtask

  task automatic run(input string name, input int unsigned budget);
    build_model();
    acc_count = 0;
    pulse_start();
    wait_run(name, budget);
    post_checks(name);
  endtask

  initial begin
    logic [15:0] img[$];
    bit          nk[$];

    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] img[$];
    bit          nk[$];

    // Reset state.
    load_rom('{16'hFFFF});
    repeat (3) @(negedge clk);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_valid", sccb_valid, 0);
    chk("reset_reg_data", {sccb_reg, sccb_data}, 0);
    chk("reset_status", {busy, done, error}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write then end marker.
    img = '{16'h1280, 16'hFFFF};
    load_rom(img);
    set_nacks('{});
    build_model();
    chk("model_single_count", exp_q.size(), 1);
    chk("model_single_lat", exp_q[0].lat, 3);
    chk("model_single_end", end_lat, 3);
    run("single", 200);
    chk("single_accepts_lit", acc_count, 1);
    chk("single_status_lit", {busy, done, error}, 3'b010);

    // Delay entry between two writes.
    img = '{16'h1280, 16'hFFF0, 16'h1180, 16'hFFFF};
    load_rom(img);
    set_nacks('{});
    build_model();
    chk("model_delay_lat", exp_q[1].lat, 1005);
    chk("model_delay_reg", exp_q[1].rg, 8'h11);
    run("delay", 3000);

    // Ready held low for 50 cycles during SEND.
    img = '{16'h3A04, 16'hFFFF};
    load_rom(img);
    set_nacks('{});
    build_model();
    acc_count = 0;
    sccb_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 20 && !sccb_valid; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    chk("stall_valid_held", sccb_valid, 1);
    chk("stall_no_accept", acc_count, 0);
    sccb_ready = 1'b1;
    wait_run("stall", 300);
    post_checks("stall");
    chk("stall_accepts_lit", acc_count, 1);

    // Start while busy is ignored; start after done re-runs from address 0.
    img = '{16'h1280, 16'h3456, 16'hFFFF};
    load_rom(img);
    set_nacks('{});
    build_model();
    acc_count = 0;
    pulse_start();
    wait_acc("busy_start", 1);
    pulse_start();
    wait_run("busy_start", 500);
    post_checks("busy_start");
    build_model();
    acc_count = 0;
    pulse_start();
    chk("restart_done_clear", done, 0);
    chk("restart_addr_zero", rom_addr, 0);
    wait_run("restart", 500);
    post_checks("restart");

`ifdef OV7670_CFG_RETRY_EN
    // Three NACKs then ACK on entry 1.
    img = '{16'h1280, 16'h3456, 16'hFFFF};
    load_rom(img);
    nk = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    set_nacks(nk);
    build_model();
    chk("model_retry_count", exp_q.size(), 5);
    run("retry_ok", 1000);
    // Four NACKs on entry 1 abort the run.
    nk = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    set_nacks(nk);
    run("retry_fail", 1000);
    chk("retry_fail_addr_lit", rom_addr, 1);
    chk("retry_fail_error_lit", error, 1);
`else
    // First NACK on entry 1 aborts the run.
    img = '{16'h1280, 16'h3456, 16'hFFFF};
    load_rom(img);
    nk = '{1'b0, 1'b1};
    set_nacks(nk);
    run("nack", 500);
    chk("nack_addr_lit", rom_addr, 1);
    chk("nack_error_lit", error, 1);
`endif

    // Reset during WAIT on entry 1, then a clean re-run.
    img = '{16'h1280, 16'h3456, 16'hFFFF};
    load_rom(img);
    set_nacks('{});
    build_model();
    acc_count = 0;
    pulse_start();
    wait_acc("rst_mid", 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_addr", rom_addr, 0);
    chk("rst_mid_sccb", {sccb_valid, sccb_reg, sccb_data}, 0);
    chk("rst_mid_status", {busy, done, error}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    set_nacks('{});
    run("rst_rerun", 500);

    // No end marker: the entry at address 255 ends the run.
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), ~8'(i)};
    set_nacks('{});
    build_model();
    chk("model_wrap_count", exp_q.size(), 256);
    chk("model_wrap_addr", end_addr, 8'hFF);
    run("wrap", 8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
